request_encoder_8to3: RTL and testbench

Sequential 8-to-3 request encoder, the return path of the 3-to-8 one-hot address decoder. Eight request lines are captured into a sticky pending register. Pending requests are issued one at a time as a 3-bit address on a valid/ready handshake, with round-robin fairness. It sits between peripheral/interrupt request sources and the control unit of the 10-bit ISA core, which consumes one index per accepted handshake.

---
 rtl/enc_pkg.sv | 8 +
 rtl/request_encoder_8to3_rr_pick8.sv | 32 +++
 rtl/request_encoder_8to3.sv | 83 ++++++++
 tb/tb_request_encoder_8to3.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared sizing and types for the 8-to-3 request encoder.
package enc_pkg;
  localparam int N_REQ  = 8;
  localparam int ADDR_W = $clog2(N_REQ);

  typedef logic [N_REQ-1:0]  req_vec_t;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/request_encoder_8to3_rr_pick8.sv
// Round-robin picker: first set bit of cand scanning upward from start, wrapping 7 -> 0.
module rr_pick8
  import enc_pkg::*;
(
  input  req_vec_t cand,
  input  addr_t    start,
  output logic     found,
  output addr_t    idx
);

  req_vec_t rot;
  addr_t    ffo;

  // Rotate right by start so bit 0 of rot is the first position scanned.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    localparam addr_t OFS = addr_t'(gi);
    addr_t src;
    assign src     = OFS + start;
    assign rot[gi] = cand[src];
  end

  always_comb begin
    ffo = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) ffo = addr_t'(i);
    end
  end

  assign found = |rot;
  assign idx   = ffo + start;

endmodule

// File: rtl/request_encoder_8to3.sv
// Sticky request capture with one-at-a-time round-robin issue on a valid/ready handshake.
module request_encoder_8to3
  import enc_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  req_vec_t req,
  input  logic     enable,
  output logic     out_valid,
  output addr_t    out_addr,
  input  logic     out_ready,
  output req_vec_t pending
);

  req_vec_t pending_reg, pending_next;
  addr_t    ptr_reg, ptr_next;
  logic     out_valid_reg, out_valid_next;
  addr_t    out_addr_reg, out_addr_next;

  logic     handshake;
  logic     load;
  logic     found;
  req_vec_t clr;
  req_vec_t cur_mask;
  req_vec_t cand;
  addr_t    start;
  addr_t    pick;

  assign handshake = out_valid_reg && out_ready;

  // clr drops the accepted bit; cur_mask hides the address already on the output.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bitsel
    assign clr[gi]      = handshake     && (out_addr_reg == ADDR_W'(gi));
    assign cur_mask[gi] = out_valid_reg && (out_addr_reg == ADDR_W'(gi));
  end

  assign cand  = pending_reg & ~cur_mask;
  assign start = handshake ? addr_t'(out_addr_reg + 3'd1) : ptr_reg;

  rr_pick8 u_pick (
    .cand  (cand),
    .start (start),
    .found (found),
    .idx   (pick)
  );

  assign load = (!out_valid_reg || handshake) && enable && found;

  always_comb begin
    pending_next   = (pending_reg & ~clr) | req;
    ptr_next       = ptr_reg;
    out_valid_next = out_valid_reg;
    out_addr_next  = out_addr_reg;
    if (handshake) begin
      ptr_next       = addr_t'(out_addr_reg + 3'd1);
      out_valid_next = 1'b0;
    end
    // A load overrides the drop so back-to-back grants have no bubble.
    if (load) begin
      out_valid_next = 1'b1;
      out_addr_next  = pick;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg   <= '0;
      ptr_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_addr_reg  <= '0;
    end else begin
      pending_reg   <= pending_next;
      ptr_reg       <= ptr_next;
      out_valid_reg <= out_valid_next;
      out_addr_reg  <= out_addr_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_addr  = out_addr_reg;
  assign pending   = pending_reg;

endmodule

// File: tb/tb_request_encoder_8to3.sv
// Bench for request_encoder_8to3: directed scenarios plus random traffic against a behavioural model.
module tb_request_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       enable;
  logic       out_valid;
  logic [2:0] out_addr;
  logic       out_ready;
  logic [7:0] pending;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: pending kept as a list of flags, addresses as plain integers.
  bit m_pend[8];
  bit m_valid;
  int m_addr;
  int m_ptr;

  always #5 clk = ~clk;

  request_encoder_8to3 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .enable    (enable),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_ready (out_ready),
    .pending   (pending)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] model_pend_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic void model_edge(input logic [7:0] r, input bit en, input bit rdy, input bit rs);
    bit hs;
    bit cand[8];
    bit found;
    int start;
    int pick;
    if (rs) begin
      for (int i = 0; i < 8; i++) m_pend[i] = 0;
      m_valid = 0;
      m_addr  = 0;
      m_ptr   = 0;
      return;
    end
    hs = m_valid && rdy;
    for (int i = 0; i < 8; i++) cand[i] = m_pend[i] && !(m_valid && i == m_addr);
    start = hs ? (m_addr + 1) % 8 : m_ptr;
    found = 0;
    pick  = 0;
    for (int k = 0; k < 8; k++) begin
      if (!found && cand[(start + k) % 8]) begin
        found = 1;
        pick  = (start + k) % 8;
      end
    end
    for (int i = 0; i < 8; i++) m_pend[i] = (m_pend[i] && !(hs && i == m_addr)) || r[i];
    if (hs) m_ptr = (m_addr + 1) % 8;
    if ((!m_valid || hs) && en && found) begin
      m_valid = 1;
      m_addr  = pick;
    end else if (hs) begin
      m_valid = 0;
    end
  endfunction

  // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
  task automatic step(input logic [7:0] r, input bit en, input bit rdy, input bit rs);
    req       = r;
    enable    = en;
    out_ready = rdy;
    rst       = rs;
    if (out_valid && rdy && !rs) $display("grant addr=%0d pending=%02h", out_addr, pending);
    @(posedge clk);
    model_edge(r, en, rdy, rs);
    @(negedge clk);
    check("out_valid", {7'd0, out_valid}, {7'd0, m_valid});
    check("out_addr",  {5'd0, out_addr},  8'(m_addr));
    check("pending",   pending,           model_pend_vec());
  endtask

  initial begin
    req = '0; enable = 1'b1; out_ready = 1'b1; rst = 1'b1;
    @(negedge clk);

    // Reset state
    step(8'h00, 1, 1, 1);
    check("reset_valid", {7'd0, out_valid}, 8'd0);
    check("reset_pend", pending, 8'h00);

    // Single request: grant of 2 two edges later, for one cycle
    step(8'h04, 1, 1, 0);
    step(8'h00, 1, 1, 0);
    check("single_addr", {5'd0, out_addr}, 8'd2);
    check("single_valid", {7'd0, out_valid}, 8'd1);
    step(8'h00, 1, 1, 0);
    check("single_done", {7'd0, out_valid}, 8'd0);

    // Burst: addresses 0..7 back to back
    step(8'h00, 1, 1, 1);
    step(8'hFF, 1, 1, 0);
    for (int i = 0; i < 8; i++) begin
      step(8'h00, 1, 1, 0);
      check("burst_addr", {5'd0, out_addr}, 8'(i));
    end
    step(8'h00, 1, 1, 0);
    check("burst_idle", {7'd0, out_valid}, 8'd0);

    // Fairness: after grant 5, requests 6 and 1 come out as 6 then 1
    step(8'h00, 1, 1, 1);
    step(8'h20, 1, 1, 0);
    step(8'h00, 1, 0, 0);
    check("fair_first", {5'd0, out_addr}, 8'd5);
    step(8'h42, 1, 1, 0);
    step(8'h00, 1, 1, 0);
    check("fair_6", {5'd0, out_addr}, 8'd6);
    step(8'h00, 1, 1, 0);
    check("fair_1", {5'd0, out_addr}, 8'd1);

    // Stall: address 3 held while req[0] pulses, then 3 then 0
    step(8'h00, 1, 1, 1);
    step(8'h08, 1, 0, 0);
    step(8'h00, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step((i % 2 == 0) ? 8'h01 : 8'h00, 1, 0, 0);
      check("stall_addr", {5'd0, out_addr}, 8'd3);
    end
    step(8'h00, 1, 1, 0);
    check("stall_next", {5'd0, out_addr}, 8'd0);

    // Re-request in the handshake cycle keeps the bit pending
    step(8'h00, 1, 1, 1);
    step(8'h10, 1, 1, 0);
    step(8'h00, 1, 1, 0);
    step(8'h10, 1, 1, 0);
    check("rereq_pend", pending, 8'h10);
    step(8'h00, 1, 1, 0);
    check("rereq_addr", {5'd0, out_addr}, 8'd4);

    // Enable gating, then reset mid-burst
    step(8'h00, 1, 1, 1);
    step(8'h81, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(8'h00, 0, 1, 0);
    check("en_hold", pending, 8'h81);
    step(8'h00, 1, 1, 0);
    check("en_g0", {5'd0, out_addr}, 8'd0);
    step(8'h00, 1, 1, 0);
    check("en_g7", {5'd0, out_addr}, 8'd7);
    step(8'hFF, 1, 1, 0);
    step(8'h00, 1, 1, 0);
    step(8'h00, 1, 1, 1);
    check("rst_valid", {7'd0, out_valid}, 8'd0);
    check("rst_pend", pending, 8'h00);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      step(r, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
